// File: rtl/mem_b_read_arbiter.sv
// Port-B read arbiter: two requesters share one 18-bit-addressed read port, with responses returned by owner tag.
// Optional starvation guard for requester 1, enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_b_read_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 24,
  parameter int READ_LAT = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr_b,
  input  logic [DATA_W-1:0] mem_rdata_b,
  output logic [2:0]        inflight
);

  if (READ_LAT < 1 || READ_LAT > 4 || MAX_WAIT < 1) begin : g_bad_param
    $error("mem_b_read_arbiter: READ_LAT must be 1..4 and MAX_WAIT >= 1");
  end

  logic                grant0;
  logic                grant1;
  logic                starve;
  logic [READ_LAT-1:0] vld_q;
  logic [READ_LAT-1:0] own_q;
  logic                rsp0_valid_q;
  logic                rsp1_valid_q;
  logic [DATA_W-1:0]   rsp0_data_q;
  logic [DATA_W-1:0]   rsp1_data_q;
  logic [2:0]          inflight_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait1_q;
  logic [WW-1:0] wait1_d;

  assign starve = (wait1_q == WW'(MAX_WAIT));

  always_comb begin
    wait1_d = wait1_q;
    if (!req1_valid || grant1) begin
      wait1_d = '0;
    end else if (wait1_q != WW'(MAX_WAIT)) begin
      wait1_d = wait1_q + WW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait1_q <= '0;
    end else begin
      wait1_q <= wait1_d;
    end
  end
`else
  assign starve = 1'b0;
`endif

  // Grants are gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    grant1 = rst_n & req1_valid & (starve | ~req0_valid);
    grant0 = rst_n & req0_valid & ~(starve & req1_valid);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign mem_rd_en  = grant0 | grant1;
  assign mem_addr_b = grant0 ? req0_addr : (grant1 ? req1_addr : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q        <= '0;
      own_q        <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      vld_q[0] <= grant0 | grant1;
      own_q[0] <= grant1;
      for (int unsigned i = 1; i < unsigned'(READ_LAT); i++) begin
        vld_q[i] <= vld_q[i-1];
        own_q[i] <= own_q[i-1];
      end
      rsp0_valid_q <= vld_q[READ_LAT-1] & ~own_q[READ_LAT-1];
      rsp1_valid_q <= vld_q[READ_LAT-1] &  own_q[READ_LAT-1];
      if (vld_q[READ_LAT-1] && !own_q[READ_LAT-1]) begin
        rsp0_data_q <= mem_rdata_b;
      end
      if (vld_q[READ_LAT-1] && own_q[READ_LAT-1]) begin
        rsp1_data_q <= mem_rdata_b;
      end
    end
  end

  always_comb begin
    inflight_d = '0;
    for (int unsigned i = 0; i < unsigned'(READ_LAT); i++) begin
      inflight_d = inflight_d + 3'(vld_q[i]);
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
  assign inflight   = inflight_d;

endmodule

// File: tb/tb_mem_b_read_arbiter.sv
// Bench for mem_b_read_arbiter: two instances (READ_LAT 1 and 3) share request inputs, each with its own memory model.
module tb_mem_b_read_arbiter;
  localparam int AW = 18;
  localparam int DW = 24;
  localparam int MW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v0 = 1'b0, v1 = 1'b0;
  logic [AW-1:0] a0 = '0, a1 = '0;

  logic r0_1, r1_1, rv0_1, rv1_1, en_1;
  logic [DW-1:0] rd0_1, rd1_1, mrd_1;
  logic [AW-1:0] ma_1;
  logic [2:0] inf_1;
  logic r0_3, r1_3, rv0_3, rv1_3, en_3;
  logic [DW-1:0] rd0_3, rd1_3, mrd_3;
  logic [AW-1:0] ma_3;
  logic [2:0] inf_3;

  always #5 clk = ~clk;

  mem_b_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .MAX_WAIT(MW)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_addr(a0), .req0_ready(r0_1), .rsp0_valid(rv0_1), .rsp0_data(rd0_1),
    .req1_valid(v1), .req1_addr(a1), .req1_ready(r1_1), .rsp1_valid(rv1_1), .rsp1_data(rd1_1),
    .mem_rd_en(en_1), .mem_addr_b(ma_1), .mem_rdata_b(mrd_1), .inflight(inf_1));

  mem_b_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3), .MAX_WAIT(MW)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_addr(a0), .req0_ready(r0_3), .rsp0_valid(rv0_3), .rsp0_data(rd0_3),
    .req1_valid(v1), .req1_addr(a1), .req1_ready(r1_3), .rsp1_valid(rv1_3), .rsp1_data(rd1_3),
    .mem_rd_en(en_3), .mem_addr_b(ma_3), .mem_rdata_b(mrd_3), .inflight(inf_3));

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    if (a == 18'd2) return 24'hABCDEF;
    return {a[5:0], a} ^ 24'h35C9A1;
  endfunction

  // Synchronous memory models: data appears READ_LAT cycles after the address edge.
  logic [DW-1:0] p1;
  logic [DW-1:0] p3 [3];
  always @(posedge clk) begin
    p1    <= en_1 ? memf(ma_1) : 24'hEEEEEE;
    p3[0] <= en_3 ? memf(ma_3) : 24'hEEEEEE;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mrd_1 = p1;
  assign mrd_3 = p3[2];

  typedef struct {
    int            cnt;
    logic          own;
    logic [DW-1:0] data;
  } rq_t;

  rq_t q1[$];
  rq_t q3[$];
  logic [DW-1:0] last1 [2];
  logic [DW-1:0] last3 [2];
  int w = 0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q1.delete();
    q3.delete();
    last1[0] = '0; last1[1] = '0;
    last3[0] = '0; last3[1] = '0;
    w = 0;
  endtask

  // One cycle: drive at negedge, check grants, model the edge, check responses at the next negedge.
  task automatic step(input logic iv0, input logic [AW-1:0] ia0, input logic iv1, input logic [AW-1:0] ia1,
                      output logic o_r0, output logic o_r1);
    logic g0, g1, st;
    logic [AW-1:0] ga;
    logic [1:0] ev1, ev3;
    rq_t e;
    v0 = iv0; a0 = ia0; v1 = iv1; a1 = ia1;
    #1;
`ifdef MEM_ARB_STARVE_GUARD_EN
    st = (w == MW);
`else
    st = 1'b0;
`endif
    g0 = iv0 && !(st && iv1);
    g1 = iv1 && !g0;
    ga = g0 ? ia0 : (g1 ? ia1 : '0);
    chk("ready0_l1", 32'(r0_1), 32'(g0));
    chk("ready1_l1", 32'(r1_1), 32'(g1));
    chk("rd_en_l1", 32'(en_1), 32'(g0 | g1));
    chk("addr_l1", 32'(ma_1), 32'(ga));
    chk("ready0_l3", 32'(r0_3), 32'(g0));
    chk("ready1_l3", 32'(r1_3), 32'(g1));
    chk("addr_l3", 32'(ma_3), 32'(ga));
    o_r0 = r0_1;
    o_r1 = r1_1;
    @(posedge clk);
    w = (iv1 && !g1) ? ((w < MW) ? w + 1 : MW) : 0;
    ev1 = '0;
    ev3 = '0;
    foreach (q1[i]) q1[i].cnt = q1[i].cnt - 1;
    foreach (q3[i]) q3[i].cnt = q3[i].cnt - 1;
    if (q1.size() > 0 && q1[0].cnt == 0) begin
      e = q1.pop_front();
      ev1[e.own] = 1'b1;
      last1[e.own] = e.data;
    end
    if (q3.size() > 0 && q3[0].cnt == 0) begin
      e = q3.pop_front();
      ev3[e.own] = 1'b1;
      last3[e.own] = e.data;
    end
    if (g0 || g1) begin
      e.own = g1;
      e.data = memf(ga);
      e.cnt = 1;
      q1.push_back(e);
      e.cnt = 3;
      q3.push_back(e);
    end
    @(negedge clk);
    chk("rsp0_valid_l1", 32'(rv0_1), 32'(ev1[0]));
    chk("rsp1_valid_l1", 32'(rv1_1), 32'(ev1[1]));
    chk("rsp0_data_l1", 32'(rd0_1), 32'(last1[0]));
    chk("rsp1_data_l1", 32'(rd1_1), 32'(last1[1]));
    chk("inflight_l1", 32'(inf_1), 32'(q1.size()));
    chk("rsp0_valid_l3", 32'(rv0_3), 32'(ev3[0]));
    chk("rsp1_valid_l3", 32'(rv1_3), 32'(ev3[1]));
    chk("rsp0_data_l3", 32'(rd0_3), 32'(last3[0]));
    chk("rsp1_data_l3", 32'(rd1_3), 32'(last3[1]));
    chk("inflight_l3", 32'(inf_3), 32'(q3.size()));
  endtask

  task automatic chk_zero();
    chk("rst_ready0", 32'(r0_1 | r0_3), 0);
    chk("rst_ready1", 32'(r1_1 | r1_3), 0);
    chk("rst_rsp_valid", 32'({rv0_1, rv1_1, rv0_3, rv1_3}), 0);
    chk("rst_rsp_data", 32'(rd0_1 | rd1_1 | rd0_3 | rd1_3), 0);
    chk("rst_rd_en", 32'(en_1 | en_3), 0);
    chk("rst_addr", 32'(ma_1 | ma_3), 0);
    chk("rst_inflight", 32'(inf_1 | inf_3), 0);
  endtask

  // Entered at a negedge; requests are held high during reset to show nothing is granted.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    v0 = 1'b1; a0 = 18'd3; v1 = 1'b1; a1 = 18'd4;
    model_clear();
    #1;
    chk_zero();
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk_zero();
    rst_n = 1'b1;
    v0 = 1'b0; v1 = 1'b0;
  endtask

  typedef struct {
    logic          v0;
    logic [AW-1:0] a0;
    logic          v1;
    logic [AW-1:0] a1;
    logic          e0;
    logic          e1;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[5];
    logic r0, r1;
    logic hv0, hv1;
    logic [AW-1:0] ha0, ha1, ca;
    int first1;

    tbl[0] = '{1'b0, 18'd0,  1'b0, 18'd0,  1'b0, 1'b0};
    tbl[1] = '{1'b1, 18'd10, 1'b0, 18'd0,  1'b1, 1'b0};
    tbl[2] = '{1'b0, 18'd0,  1'b1, 18'd11, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 18'd12, 1'b1, 18'd13, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 18'd0,  1'b0, 18'd0,  1'b0, 1'b0};

    @(negedge clk);
    do_reset(2);

    foreach (tbl[i]) begin
      step(tbl[i].v0, tbl[i].a0, tbl[i].v1, tbl[i].a1, r0, r1);
      chk("tbl_ready0", 32'(r0), 32'(tbl[i].e0));
      chk("tbl_ready1", 32'(r1), 32'(tbl[i].e1));
    end
    repeat (4) step(1'b0, '0, 1'b0, '0, r0, r1);

    // Single read of address 2.
    step(1'b1, 18'd2, 1'b0, '0, r0, r1);
    chk("single_ready", 32'(r0), 1);
    step(1'b0, '0, 1'b0, '0, r0, r1);
    chk("single_rsp_valid", 32'(rv0_1), 1);
    chk("single_rsp_data", 32'(rd0_1), 32'h00ABCDEF);
    chk("single_rsp1_quiet", 32'(rv1_1), 0);
    repeat (3) step(1'b0, '0, 1'b0, '0, r0, r1);

    // Streaming addresses 0..7.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 18'(i), 1'b0, '0, r0, r1);
      chk("stream_inflight", 32'(inf_1), 1);
      if (i > 0) begin
        chk("stream_rsp_valid", 32'(rv0_1), 1);
        chk("stream_rsp_data", 32'(rd0_1), 32'(memf(18'(i - 1))));
      end
    end
    step(1'b0, '0, 1'b0, '0, r0, r1);
    chk("stream_last_data", 32'(rd0_1), 32'(memf(18'd7)));
    repeat (3) step(1'b0, '0, 1'b0, '0, r0, r1);

    // Contention: both requesters valid for 20 cycles.
    first1 = -1;
    hv1 = 1'b1;
    ca = 18'd20;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, ca, hv1, 18'd100, r0, r1);
      if (r0) ca = ca + 18'd1;
      if (r1 && first1 < 0) begin
        first1 = i;
        chk("starve_r0_stalled", 32'(r0), 0);
        hv1 = 1'b0;
      end
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    chk("starve_grant_cycle", 32'(first1), 32'd8);
    step(1'b0, '0, 1'b0, '0, r0, r1);
`else
    chk("no_grant1_under_load", 32'(first1), 32'hFFFFFFFF);
    step(1'b0, '0, 1'b1, 18'd100, r0, r1);
    chk("grant1_after_drop", 32'(r1), 1);
`endif
    repeat (4) step(1'b0, '0, 1'b0, '0, r0, r1);

    // Ownership with the 3-cycle instance.
    step(1'b1, 18'd4, 1'b0, '0, r0, r1);
    step(1'b0, '0, 1'b1, 18'd5, r0, r1);
    step(1'b0, '0, 1'b0, '0, r0, r1);
    step(1'b0, '0, 1'b0, '0, r0, r1);
    chk("own_rsp0_valid", 32'(rv0_3), 1);
    chk("own_rsp0_data", 32'(rd0_3), 32'(memf(18'd4)));
    chk("own_rsp1_early", 32'(rv1_3), 0);
    step(1'b0, '0, 1'b0, '0, r0, r1);
    chk("own_rsp1_valid", 32'(rv1_3), 1);
    chk("own_rsp1_data", 32'(rd1_3), 32'(memf(18'd5)));
    chk("own_rsp0_done", 32'(rv0_3), 0);
    repeat (3) step(1'b0, '0, 1'b0, '0, r0, r1);

    // Reset with two reads in flight; the model expects no response afterwards.
    step(1'b1, 18'd6, 1'b0, '0, r0, r1);
    step(1'b1, 18'd7, 1'b0, '0, r0, r1);
    chk("pre_reset_inflight", 32'(inf_3), 2);
    do_reset(2);
    repeat (5) step(1'b0, '0, 1'b0, '0, r0, r1);
    step(1'b1, 18'd9, 1'b0, '0, r0, r1);
    chk("post_reset_accept", 32'(r0), 1);
    step(1'b0, '0, 1'b0, '0, r0, r1);
    chk("post_reset_rsp", 32'(rd0_1), 32'(memf(18'd9)));
    repeat (3) step(1'b0, '0, 1'b0, '0, r0, r1);

    // Random traffic; a request is held until accepted.
    hv0 = 1'b0; hv1 = 1'b0; ha0 = '0; ha1 = '0;
    for (int n = 0; n < 400; n++) begin
      if (!hv0) begin
        hv0 = ($urandom_range(0, 9) < 6);
        ha0 = 18'($urandom_range(0, 4095));
      end
      if (!hv1) begin
        hv1 = ($urandom_range(0, 9) < 5);
        ha1 = 18'($urandom_range(0, 4095));
      end
      step(hv0, ha0, hv1, ha1, r0, r1);
      if (r0) hv0 = 1'b0;
      if (r1) hv1 = 1'b0;
    end
    repeat (5) step(1'b0, '0, 1'b0, '0, r0, r1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_b_read_arbiter.md
# mem_b_read_arbiter

Arbitrates the single 18-bit read port (port B) of the data memory between two read requesters: requester 0, the display scan-out, and requester 1, the debug/host read path. It accepts at most one read per cycle, drives the memory port, and returns each read word to its owner after a fixed latency. An optional starvation guard keeps requester 1 from being locked out while the display is streaming.

## Interface
- ADDR_W, 18, word address width of port B
- DATA_W, 24, read data width of port B
- READ_LAT, 1, memory read latency in cycles (legal range 1..4)
- MAX_WAIT, 8, consecutive denied cycles before requester 1 is forced through (starvation guard only)

- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 read request
- req0_addr  in  ADDR_W  requester 0 address
- req0_ready  out  1  requester 0 accepted this cycle (combinational)
- rsp0_valid  out  1  requester 0 read data valid, one-cycle pulse
- rsp0_data  out  DATA_W  requester 0 read data
- req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data  same as the requester 0 signals, for requester 1
- mem_rd_en  out  1  read strobe to port B (combinational)
- mem_addr_b  out  ADDR_W  port B address (combinational, the granted address)
- mem_rdata_b  in  DATA_W  port B read data, valid READ_LAT cycles after the address edge
- inflight  out  3  number of accepted reads whose response is still pending

## Operation
- Handshake: a request is accepted on a rising edge where valid && ready. The requester holds valid and addr stable until it is accepted. Behaviour is undefined if addr changes while valid is high and ready is low.
- Arbitration (combinational, every cycle):
  - Default: requester 0 has strict priority.
  - Exactly one of req0_ready and req1_ready may be high, and only when the matching valid is high.
- mem_rd_en = req0_ready | req1_ready.
- mem_addr_b = the granted address, or 0 when there is no grant.
- Tag pipeline: a shift register of READ_LAT stages. Each stage holds {valid, owner}. Stage 0 is loaded at the acceptance edge.
- On the edge where the last stage is valid, the arbiter registers mem_rdata_b into rsp0_data or rsp1_data according to owner. It pulses the matching rsp*_valid for exactly one cycle.
- The rsp*_data of the requester not being served holds its previous value.
- inflight counts the valid stages. Its maximum is READ_LAT, which stays at or below 4 and fits in 3 bits.
- Back-to-back reads are accepted every cycle with no bubbles. Responses are returned in acceptance order.

## Timing
- Reset values:
  - req*_ready = 0 while rst_n is low.
  - rsp0_valid = rsp1_valid = 0.
  - rsp0_data = rsp1_data = 0.
  - mem_rd_en = 0 and mem_addr_b = 0.
  - inflight = 0; all tag stages invalid; wait counter = 0.
- Latency: for a request accepted at edge E0, rsp*_valid is high during the cycle that starts at edge E0+READ_LAT. With READ_LAT=1, data appears one cycle after acceptance.
- Simultaneous requests: one grant per cycle. The loser sees ready=0 and retries next cycle with valid still held.
- A response and a new acceptance on the same edge: both are handled, and inflight stays unchanged.
- Reset asserted mid-operation: all in-flight reads are discarded and no response pulse follows. The first request after rst_n deasserts is accepted on the first rising edge.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined:
  - A saturating counter wait1 (0..MAX_WAIT) increments on every edge where req1_valid && !req1_ready.
  - wait1 clears when requester 1 is accepted or when req1_valid is low.
  - While wait1 == MAX_WAIT, requester 1 has priority over requester 0.
  - Consequence: requester 1 is granted no later than MAX_WAIT+1 cycles after raising valid.
- MEM_ARB_STARVE_GUARD_EN undefined:
  - No counter logic is present.
  - Requester 0 has strict priority, so requester 1 can wait indefinitely.

## Test plan
- Single read, READ_LAT=1, mem holds 0xABCDEF at address 2: req0 addr 2 for one cycle -> req0_ready=1 that cycle, mem_addr_b=2, one cycle later rsp0_valid=1 with rsp0_data=0xABCDEF, rsp1_valid stays 0.
- Streaming: req0 valid for 8 cycles with addresses 0..7 -> 8 consecutive rsp0_valid pulses in address order, inflight steady at 1, no bubbles.
- Contention, guard off: req0 and req1 both valid for 20 cycles -> req1_ready stays 0 throughout; req1 is granted in the cycle after req0_valid drops.
- Contention, guard on, MAX_WAIT=8: req0 and req1 both valid continuously -> req1 is accepted at the 9th cycle and req0 is stalled for exactly that one cycle.
- Ownership with READ_LAT=3: accept req0 addr 4, then req1 addr 5 on the next edge -> rsp0_valid three cycles after the first acceptance with mem[4], then rsp1_valid one cycle later with mem[5].
- Reset mid-flight: rst_n pulsed low while inflight=2 -> no rsp pulse ever appears; all outputs are 0 during reset; a new request after reset completes normally.
